hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS datapath. It sequences the IF/ID pipeline register, the PC register and the ID/EX register.
- It detects load-use hazards, applies branch-taken flushes, freezes the pipe during data-memory wait, and handles a halt.
- It drives the write-enable and flush controls for PC, IF/ID and ID/EX, and keeps saturating stall and flush statistics counters.

Parameters:
- LOAD_STALL_CYCLES, 1, total bubble cycles inserted per load-use hazard (1..15).
- FLUSH_CYCLES, 1, cycles IF/ID and ID/EX are flushed per taken branch (1..15).
- CNT_W, 16, width of the StallCount and FlushCount statistics counters.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  reset, asynchronous, active-high.
- ID_Rs  in  5  rs field of the instruction in ID.
- ID_Rt  in  5  rt field of the instruction in ID.
- ID_UsesRt  in  1  the ID instruction reads rt as a source.
- EX_MemRead  in  1  the instruction in EX is a load.
- EX_Rt  in  5  destination register of the load in EX.
- BranchTaken  in  1  branch resolved taken in EX this cycle.
- DMemBusy  in  1  data memory not ready; the whole pipe must freeze.
- Halt  in  1  halt instruction decoded in ID.
- PCWrite  out  1  PC load enable.
- IF_ID_Write  out  1  IF/ID register load enable.
- IF_ID_Flush  out  1  IF/ID register loads zero (nop).
- ID_EX_Flush  out  1  ID/EX register loads a bubble.
- StallCount  out  CNT_W  cycles with IF_ID_Write=0 and not halted; saturating.
- FlushCount  out  CNT_W  cycles with IF_ID_Flush=1; saturating.
- State  out  2  FSM state, for debug.

Behaviour:
- Registered state: State, a 4-bit down counter Cnt, StallCount, FlushCount. All outputs are combinational from state and inputs (Mealy).
- State encodings: RUN=0, LU_STALL=1, FLUSH=2, HALTED=3.
- Reset is asynchronous. While Reset=1: State=RUN, Cnt=0, StallCount=0, FlushCount=0, and PCWrite=IF_ID_Write=IF_ID_Flush=ID_EX_Flush=0.
- Normal outputs: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Flush=0.
- Freeze outputs: all four controls 0.
- Hazard H is true when EX_MemRead=1, EX_Rt!=0, and either EX_Rt==ID_Rs or (ID_UsesRt=1 and EX_Rt==ID_Rt).
- Priority is checked in this order every cycle in RUN, LU_STALL and FLUSH:
  1. DMemBusy=1: freeze outputs. State and Cnt hold. StallCount increments.
  2. BranchTaken=1: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Flush=1. If FLUSH_CYCLES>1, go to FLUSH with Cnt=FLUSH_CYCLES-2; otherwise go to RUN. This overrides and restarts any LU_STALL or FLUSH in progress.
  3. Halt=1 in RUN with no hazard: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=0; go to HALTED.
  4. RUN with H=1: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1. If LOAD_STALL_CYCLES>1, go to LU_STALL with Cnt=LOAD_STALL_CYCLES-2; otherwise stay in RUN.
  5. LU_STALL: same outputs as rule 4. If Cnt==0 go to RUN, else Cnt decrements. Hazard detection is ignored in this state.
  6. FLUSH: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Flush=1. If Cnt==0 go to RUN, else Cnt decrements.
  7. RUN with no event: normal outputs.
- HALTED: freeze outputs; all inputs ignored; counters hold. Only Reset exits this state.
- StallCount increments in any cycle that is not Reset and not HALTED where IF_ID_Write=0. Saturates at all-ones.
- FlushCount increments in any cycle where IF_ID_Flush=1. Saturates at all-ones.
- EX_Rt=0 never causes a stall.
- Reset asserted mid-stall or mid-flush aborts immediately to RUN with all counters at 0.

Test Plan:
- Reset, then EX_MemRead=1, EX_Rt=8, ID_Rs=8 for 1 cycle -> PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1 for exactly 1 cycle; StallCount=1.
- LOAD_STALL_CYCLES=3, same hazard pulsed 1 cycle -> 3 consecutive stall cycles, State 0→1→1→0; StallCount=3.
- EX_Rt=0, ID_Rs=0, EX_MemRead=1 -> no stall. ID_UsesRt=0 with EX_Rt==ID_Rt=5 -> no stall.
- FLUSH_CYCLES=2, BranchTaken pulse -> IF_ID_Flush=1 and ID_EX_Flush=1 for 2 cycles with PCWrite=1; FlushCount=2.
- DMemBusy=1 for 4 cycles during LU_STALL (LOAD_STALL_CYCLES=3) -> freeze outputs, Cnt holds, stall resumes after; StallCount=3+4=7.
- Halt=1 -> HALTED with all controls 0; BranchTaken afterwards ignored. Assert Reset -> State=0, counters 0. Also, CNT_W=2 with 5 stalls -> StallCount saturates at 3.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory-wait freeze and halt
// for the 5-stage datapath, with saturating stall/flush statistics counters.
module hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES      = 1,
  parameter int unsigned CNT_W             = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Rt,
  input  logic             BranchTaken,
  input  logic             DMemBusy,
  input  logic             Halt,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount,
  output logic [1:0]       State
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLuStall = 2'd1,
    StFlush   = 2'd2,
    StHalted  = 2'd3
  } state_e;

  // Cnt holds the number of extra cycles left after the current one.
  localparam logic [3:0] LuInit = (LOAD_STALL_CYCLES > 1) ? 4'(LOAD_STALL_CYCLES - 2) : 4'd0;
  localparam logic [3:0] FlInit = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;
  localparam bit         LuMulti = (LOAD_STALL_CYCLES > 1);
  localparam bit         FlMulti = (FLUSH_CYCLES > 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic hazard;
  logic pc_write, if_id_write, if_id_flush, id_ex_flush;

  assign hazard = EX_MemRead && (EX_Rt != 5'd0) &&
                  ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (state_q != StHalted && !DMemBusy) begin
      if (BranchTaken) begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        state_d     = FlMulti ? StFlush : StRun;
        cnt_d       = FlMulti ? FlInit : cnt_q;
      end else begin
        unique case (state_q)
          StRun: begin
            if (hazard) begin
              id_ex_flush = 1'b1;
              state_d     = LuMulti ? StLuStall : StRun;
              cnt_d       = LuMulti ? LuInit : cnt_q;
            end else if (Halt) begin
              state_d = StHalted;
            end else begin
              pc_write    = 1'b1;
              if_id_write = 1'b1;
            end
          end
          StLuStall: begin
            id_ex_flush = 1'b1;
            if (cnt_q == 4'd0) state_d = StRun;
            else               cnt_d   = cnt_q - 4'd1;
          end
          StFlush: begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (cnt_q == 4'd0) state_d = StRun;
            else               cnt_d   = cnt_q - 4'd1;
          end
          default: ;
        endcase
      end
    end

    stall_count_d = stall_count_q;
    if (state_q != StHalted && !if_id_write && stall_count_q != '1) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
    flush_count_d = flush_count_q;
    if (if_id_flush && flush_count_q != '1) begin
      flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= StRun;
      cnt_q         <= 4'd0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  // Controls are forced low for as long as Reset is held.
  assign PCWrite     = pc_write && !Reset;
  assign IF_ID_Write = if_id_write && !Reset;
  assign IF_ID_Flush = if_id_flush && !Reset;
  assign ID_EX_Flush = id_ex_flush && !Reset;
  assign StallCount  = stall_count_q;
  assign FlushCount  = flush_count_q;
  assign State       = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (3/2/16 and 1/1/2) driven by directed
// vectors; expected values are pushed at drive time and checked by a separate monitor.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       memrd;
    logic [4:0] ex_rt;
    logic       br;
    logic       busy;
    logic       halt;
  } in_t;

  typedef struct {
    bit          dut;
    logic [3:0]  ctl;
    logic [1:0]  st;
    int unsigned stall;
    int unsigned flush;
    int          idx;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t in_a, in_b;
  logic        pcw_a, ifw_a, iff_a, idf_a, pcw_b, ifw_b, iff_b, idf_b;
  logic [15:0] stc_a, flc_a;
  logic [1:0]  stc_b, flc_b;
  logic [1:0]  st_a, st_b;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   n = 0;

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(16)) u_a (
    .Clk(clk), .Reset(in_a.rst), .ID_Rs(in_a.rs), .ID_Rt(in_a.rt), .ID_UsesRt(in_a.uses_rt),
    .EX_MemRead(in_a.memrd), .EX_Rt(in_a.ex_rt), .BranchTaken(in_a.br), .DMemBusy(in_a.busy),
    .Halt(in_a.halt), .PCWrite(pcw_a), .IF_ID_Write(ifw_a), .IF_ID_Flush(iff_a),
    .ID_EX_Flush(idf_a), .StallCount(stc_a), .FlushCount(flc_a), .State(st_a)
  );

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(2)) u_b (
    .Clk(clk), .Reset(in_b.rst), .ID_Rs(in_b.rs), .ID_Rt(in_b.rt), .ID_UsesRt(in_b.uses_rt),
    .EX_MemRead(in_b.memrd), .EX_Rt(in_b.ex_rt), .BranchTaken(in_b.br), .DMemBusy(in_b.busy),
    .Halt(in_b.halt), .PCWrite(pcw_b), .IF_ID_Write(ifw_b), .IF_ID_Flush(iff_b),
    .ID_EX_Flush(idf_b), .StallCount(stc_b), .FlushCount(flc_b), .State(st_b)
  );

  function automatic in_t mk(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                             input logic uses, input logic memrd, input logic [4:0] ex_rt,
                             input logic br, input logic busy, input logic halt);
    in_t v;
    v = '{rst: rst, rs: rs, rt: rt, uses_rt: uses, memrd: memrd, ex_rt: ex_rt,
          br: br, busy: busy, halt: halt};
    return v;
  endfunction

  function automatic in_t i_idle();  return mk(0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic in_t i_rst();   return mk(1, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic in_t i_haz();   return mk(0, 8, 0, 0, 1, 8, 0, 0, 0); endfunction
  function automatic in_t i_br();    return mk(0, 0, 0, 0, 0, 0, 1, 0, 0); endfunction
  function automatic in_t i_busy();  return mk(0, 0, 0, 0, 0, 0, 0, 1, 0); endfunction
  function automatic in_t i_halt();  return mk(0, 0, 0, 0, 0, 0, 0, 0, 1); endfunction

  // ctl = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}; st/stall/flush are pre-edge values.
  task automatic step(input bit d, input in_t v, input logic [3:0] ctl, input logic [1:0] s,
                      input int unsigned stl, input int unsigned fl);
    exp_t e;
    @(posedge clk);
    #1;
    if (d == 1'b0) in_a = v;
    else           in_b = v;
    e = '{dut: d, ctl: ctl, st: s, stall: stl, flush: fl, idx: n};
    q.push_back(e);
    n++;
  endtask

  task automatic cmp(input string name, input int idx, input int unsigned act,
                     input int unsigned req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%0d required=%0d", name, idx, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.dut == 1'b0) begin
        cmp("ctl_a", e.idx, {28'd0, pcw_a, ifw_a, iff_a, idf_a}, {28'd0, e.ctl});
        cmp("state_a", e.idx, {30'd0, st_a}, {30'd0, e.st});
        cmp("stall_a", e.idx, {16'd0, stc_a}, e.stall);
        cmp("flush_a", e.idx, {16'd0, flc_a}, e.flush);
      end else begin
        cmp("ctl_b", e.idx, {28'd0, pcw_b, ifw_b, iff_b, idf_b}, {28'd0, e.ctl});
        cmp("state_b", e.idx, {30'd0, st_b}, {30'd0, e.st});
        cmp("stall_b", e.idx, {30'd0, stc_b}, e.stall);
        cmp("flush_b", e.idx, {30'd0, flc_b}, e.flush);
      end
    end
  end

  initial begin
    in_a = i_rst();
    in_b = i_rst();
    // Instance A: LOAD_STALL_CYCLES=3, FLUSH_CYCLES=2
    step(0, i_rst(),  4'b0000, 0, 0, 0);
    step(0, i_idle(), 4'b1100, 0, 0, 0);
    step(0, i_haz(),  4'b0001, 0, 0, 0);
    step(0, i_idle(), 4'b0001, 1, 1, 0);
    step(0, i_idle(), 4'b0001, 1, 2, 0);
    step(0, i_idle(), 4'b1100, 0, 3, 0);
    step(0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0), 4'b1100, 0, 3, 0);  // EX_Rt=0 never stalls
    step(0, mk(0, 1, 5, 0, 1, 5, 0, 0, 0), 4'b1100, 0, 3, 0);  // rt match but not used
    step(0, mk(0, 1, 5, 1, 1, 5, 0, 0, 0), 4'b0001, 0, 3, 0);  // rt match and used
    step(0, i_busy(), 4'b0000, 1, 4, 0);
    step(0, i_busy(), 4'b0000, 1, 5, 0);
    step(0, i_busy(), 4'b0000, 1, 6, 0);
    step(0, i_busy(), 4'b0000, 1, 7, 0);
    step(0, i_idle(), 4'b0001, 1, 8, 0);
    step(0, i_idle(), 4'b0001, 1, 9, 0);
    step(0, i_idle(), 4'b1100, 0, 10, 0);
    step(0, i_br(),   4'b1111, 0, 10, 0);
    step(0, i_idle(), 4'b1111, 2, 10, 1);
    step(0, i_idle(), 4'b1100, 0, 10, 2);
    step(0, i_haz(),  4'b0001, 0, 10, 2);
    step(0, i_br(),   4'b1111, 1, 11, 2);  // branch overrides stall in progress
    step(0, i_haz(),  4'b1111, 2, 11, 3);  // hazard ignored while flushing
    step(0, i_idle(), 4'b1100, 0, 11, 4);
    step(0, mk(0, 8, 0, 0, 1, 8, 0, 0, 1), 4'b0001, 0, 11, 4);  // hazard beats halt
    step(0, i_idle(), 4'b0001, 1, 12, 4);
    step(0, i_idle(), 4'b0001, 1, 13, 4);
    step(0, i_halt(), 4'b0000, 0, 14, 4);
    step(0, i_br(),   4'b0000, 3, 15, 4);
    step(0, mk(0, 8, 0, 0, 1, 8, 1, 1, 0), 4'b0000, 3, 15, 4);
    step(0, i_rst(),  4'b0000, 0, 0, 0);
    step(0, i_idle(), 4'b1100, 0, 0, 0);
    step(0, i_haz(),  4'b0001, 0, 0, 0);
    step(0, i_rst(),  4'b0000, 0, 0, 0);  // reset mid-stall
    step(0, i_idle(), 4'b1100, 0, 0, 0);
    // Instance B: single-cycle stall/flush, 2-bit saturating counters
    step(1, i_rst(),  4'b0000, 0, 0, 0);
    step(1, i_haz(),  4'b0001, 0, 0, 0);
    step(1, i_idle(), 4'b1100, 0, 1, 0);
    step(1, i_haz(),  4'b0001, 0, 1, 0);
    step(1, i_haz(),  4'b0001, 0, 2, 0);
    step(1, i_haz(),  4'b0001, 0, 3, 0);
    step(1, i_haz(),  4'b0001, 0, 3, 0);
    step(1, i_idle(), 4'b1100, 0, 3, 0);
    step(1, i_br(),   4'b1111, 0, 3, 0);
    step(1, i_br(),   4'b1111, 0, 3, 1);
    step(1, i_br(),   4'b1111, 0, 3, 2);
    step(1, i_br(),   4'b1111, 0, 3, 3);
    step(1, i_idle(), 4'b1100, 0, 3, 3);

    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0 pending expectations", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
